pixel_alu_pipe: RTL and testbench

//  Parametrised successor to the single-cell image processor core. Applies one

---
 rtl/pixel_alu_pipe.sv | 162 ++++++++++++++++
 tb/tb_pixel_alu_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_alu_pipe.sv
// Two-stage lane-wise pixel ALU with valid/ready on both sides.
// Ports: clk, rst (async low), in_* beat (op,a,b,k), out_* beat (pix,sat,err).
module pixel_alu_pipe #(
  parameter int CH_W = 8,
  parameter int CH_N = 3,
  parameter int OP_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      in_op,
  input  logic [CH_N*CH_W-1:0] in_a,
  input  logic [CH_N*CH_W-1:0] in_b,
  input  logic [CH_W-1:0]      in_k,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH_N*CH_W-1:0] out_pix,
  output logic [CH_N-1:0]      out_sat,
  output logic                 out_err
);

  localparam int PW = CH_N * CH_W;
  localparam int GW = CH_W + $clog2(CH_N);
  localparam int BW = 2 * CH_W + 1;
  localparam logic [CH_W-1:0] MAXV = {CH_W{1'b1}};

  localparam logic [OP_W-1:0] OP_PASSA = OP_W'(0);
  localparam logic [OP_W-1:0] OP_PASSB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADDS  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUBS  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_AVG   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MIN   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MAX   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ABSD  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(9);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_NOTA  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_THR   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_BLEND = OP_W'(13);
  localparam logic [OP_W-1:0] OP_SHL   = OP_W'(14);
  localparam logic [OP_W-1:0] OP_SHR   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_GRAY  = OP_W'(16);

  logic            init_q;
  logic            s1_valid_q;
  logic [OP_W-1:0] s1_op_q;
  logic [PW-1:0]   s1_a_q;
  logic [PW-1:0]   s1_b_q;
  logic [CH_W-1:0] s1_k_q;
  logic            s2_valid_q;
  logic [PW-1:0]   s2_pix_q;
  logic [CH_N-1:0] s2_sat_q;
  logic            s2_err_q;

  logic [PW-1:0]   pix_d;
  logic [CH_N-1:0] sat_d;
  logic            err_d;
  logic [GW-1:0]   gsum;
  logic [CH_W-1:0] gray;
  logic            adv;

  // Whole pipe moves together; bubbles advance like data.
  assign adv       = !s2_valid_q || out_ready;
  // Held low through reset and the first clock after release.
  assign in_ready  = adv && init_q;
  assign out_valid = s2_valid_q;
  assign out_pix   = s2_pix_q;
  assign out_sat   = s2_sat_q;
  assign out_err   = s2_err_q;

  always_comb begin
    logic [CH_W-1:0]  a, b, r;
    logic [CH_W:0]    sum, dif;
    logic [BW-1:0]    bl;
    logic [CH_W+15:0] shl;
    logic [3:0]       sh;
    logic             st;
    gsum = '0;
    for (int i = 0; i < CH_N; i++) begin
      gsum = gsum + GW'(s1_a_q[i*CH_W +: CH_W]);
    end
    gray  = CH_W'(gsum / GW'(CH_N));
    pix_d = '0;
    sat_d = '0;
    err_d = s1_op_q > OP_GRAY;
    sh    = s1_k_q[3:0];
    for (int i = 0; i < CH_N; i++) begin
      a   = s1_a_q[i*CH_W +: CH_W];
      b   = s1_b_q[i*CH_W +: CH_W];
      sum = {1'b0, a} + {1'b0, b};
      // MSB of dif is the borrow out of a-b.
      dif = {1'b0, a} - {1'b0, b};
      bl  = BW'(a) * BW'(s1_k_q)
          + BW'(b) * BW'(MAXV - s1_k_q);
      shl = (CH_W+16)'(a) << sh;
      r   = '0;
      st  = 1'b0;
      unique case (s1_op_q)
        OP_PASSA: r = a;
        OP_PASSB: r = b;
        OP_ADDS: begin
          st = sum[CH_W];
          r  = st ? MAXV : sum[CH_W-1:0];
        end
        OP_SUBS: begin
          st = dif[CH_W];
          r  = st ? '0 : dif[CH_W-1:0];
        end
        OP_AVG:   r = sum[CH_W:1];
        OP_MIN:   r = (a < b) ? a : b;
        OP_MAX:   r = (a < b) ? b : a;
        OP_ABSD:  r = (a < b) ? b - a : a - b;
        OP_AND:   r = a & b;
        OP_OR:    r = a | b;
        OP_XOR:   r = a ^ b;
        OP_NOTA:  r = ~a;
        OP_THR:   r = (a >= s1_k_q) ? MAXV : '0;
        OP_BLEND: r = CH_W'(bl / BW'(MAXV));
        OP_SHL: begin
          st = |shl[CH_W+15:CH_W];
          r  = st ? MAXV : shl[CH_W-1:0];
        end
        OP_SHR:   r = a >> sh;
        OP_GRAY:  r = gray;
        default:  r = '0;
      endcase
      pix_d[i*CH_W +: CH_W] = r;
      sat_d[i]              = st;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_k_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_pix_q   <= '0;
      s2_sat_q   <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (adv) begin
        s1_valid_q <= in_valid && in_ready;
        s1_op_q    <= in_op;
        s1_a_q     <= in_a;
        s1_b_q     <= in_b;
        s1_k_q     <= in_k;
        s2_valid_q <= s1_valid_q;
        s2_pix_q   <= pix_d;
        s2_sat_q   <= sat_d;
        s2_err_q   <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_pixel_alu_pipe.sv
// Randomized + directed bench for pixel_alu_pipe (CH_W=8, CH_N=3).
// Behavioural model feeds a scoreboard checked at every output beat.
module tb_pixel_alu_pipe;

  typedef struct packed {
    logic       err;
    logic [2:0] sat;
    logic [23:0] pix;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = '0;
  logic [23:0] in_a = '0;
  logic [23:0] in_b = '0;
  logic [7:0]  in_k = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_pix;
  logic [2:0]  out_sat;
  logic        out_err;

  int   checks = 0;
  int   failures = 0;
  res_t exp_q[$];
  res_t held;
  bit   stall_prev = 1'b0;
  bit   rnd_done = 1'b0;

  always #5 clk = ~clk;

  pixel_alu_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_k(in_k),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pix(out_pix), .out_sat(out_sat), .out_err(out_err)
  );

  task automatic check(input string nm,
                       input logic [27:0] act,
                       input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [4:0] op,
                                 input logic [23:0] A,
                                 input logic [23:0] B,
                                 input logic [7:0] K);
    res_t r;
    int a, b, k, v, s;
    r = '0;
    k = int'(K);
    if (op > 5'h10) begin
      r.err = 1'b1;
      return r;
    end
    if (op == 5'h10) begin
      v = (int'(A[7:0]) + int'(A[15:8]) + int'(A[23:16])) / 3;
      r.pix = {3{8'(v)}};
      return r;
    end
    for (int i = 0; i < 3; i++) begin
      a = int'(A[i*8 +: 8]);
      b = int'(B[i*8 +: 8]);
      s = k % 16;
      case (op)
        5'h00: v = a;
        5'h01: v = b;
        5'h02: v = a + b;
        5'h03: v = a - b;
        5'h04: v = (a + b) / 2;
        5'h05: v = (a < b) ? a : b;
        5'h06: v = (a > b) ? a : b;
        5'h07: v = (a > b) ? a - b : b - a;
        5'h08: v = a & b;
        5'h09: v = a | b;
        5'h0A: v = a ^ b;
        5'h0B: v = 255 - a;
        5'h0C: v = (a >= k) ? 255 : 0;
        5'h0D: v = (a * k + b * (255 - k)) / 255;
        5'h0E: v = a * (1 << s);
        5'h0F: v = (s >= 8) ? 0 : a / (1 << s);
        default: v = 0;
      endcase
      if (v > 255) begin v = 255; r.sat[i] = 1'b1; end
      if (v < 0)   begin v = 0;   r.sat[i] = 1'b1; end
      r.pix[i*8 +: 8] = 8'(v);
    end
    return r;
  endfunction

  // Scoreboard, output stability and reset flush.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 28'(out_valid), 28'd1);
        check("stall_stable", {out_err, out_sat, out_pix}, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat got=%h want=none t=%0t", out_pix, $time);
        end else begin
          check("beat", {out_err, out_sat, out_pix}, exp_q.pop_front());
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {out_err, out_sat, out_pix};
      if (in_valid && in_ready)
        exp_q.push_back(model(in_op, in_a, in_b, in_k));
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [4:0] op, input logic [23:0] a,
                      input logic [23:0] b, input logic [7:0] k);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_op = op; in_a = a; in_b = b; in_k = k;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout got=stalled want=accept t=%0t", $time);
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Model pinned to hand-computed values.
    check("pin_adds", model(5'h02, 24'hC810FF, 24'h5020_01, 8'h00),
          {1'b0, 3'b101, 24'hFF30FF});
    check("pin_blend80", model(5'h0D, 24'hFF0040, 24'h00FF40, 8'h80),
          {1'b0, 3'b000, 24'h807F40});
    check("pin_blendff", model(5'h0D, 24'h12AB34, 24'h9876FE, 8'hFF),
          {1'b0, 3'b000, 24'h12AB34});
    check("pin_illegal", model(5'h1A, 24'hFFFFFF, 24'hFFFFFF, 8'h00),
          {1'b1, 3'b000, 24'h000000});
    check("pin_gray", model(5'h10, 24'h306090, 24'h0, 8'h00),
          {1'b0, 3'b000, 24'h606060});
    check("pin_shr9", model(5'h0F, 24'hFFFFFF, 24'h0, 8'h09),
          {1'b0, 3'b000, 24'h000000});
    check("pin_shl1", model(5'h0E, 24'h909090, 24'h0, 8'h01),
          {1'b0, 3'b111, 24'hFFFFFF});

    // Reset held with a beat offered.
    in_valid = 1'b1; in_op = 5'h02;
    in_a = 24'hC810FF; in_b = 24'h502001;
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", 28'(out_valid), 28'd0);
      check("rst_out_pix", 28'(out_pix), 28'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 28'(in_ready), 28'd1);
    @(posedge clk); #1;

    // ADDS latency: out_valid exactly two clocks after offer.
    send(5'h02, 24'hC810FF, 24'h502001, 8'h00);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_early", 28'(out_valid), 28'd0);
    @(negedge clk);
    check("lat_valid", 28'(out_valid), 28'd1);
    check("adds_dut", {out_err, out_sat, out_pix},
          {1'b0, 3'b101, 24'hFF30FF});
    @(posedge clk); #1;

    send(5'h0D, 24'hFF0040, 24'h00FF40, 8'h80);
    send(5'h0D, 24'h12AB34, 24'h9876FE, 8'hFF);
    send(5'h1A, 24'hFFFFFF, 24'hFFFFFF, 8'h00);
    send(5'h00, 24'h010203, 24'h0, 8'h00);
    send(5'h10, 24'h306090, 24'h0, 8'h00);
    send(5'h0F, 24'hFFFFFF, 24'h0, 8'h09);
    send(5'h0E, 24'h909090, 24'h0, 8'h01);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Backpressure during a 6-beat burst.
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(5'($urandom_range(0, 16)), 24'($urandom),
               24'($urandom), 8'($urandom));
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready", 28'(in_ready), 28'd0);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("bp_drained", 28'(exp_q.size()), 28'd0);

    // Random traffic with random backpressure.
    fork
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom % 4) != 0;
        end
      end
      begin
        for (int i = 0; i < 400; i++) begin
          send(($urandom % 8 == 0) ? 5'($urandom_range(17, 31))
                                   : 5'($urandom_range(0, 16)),
               24'($urandom), 24'($urandom), 8'($urandom));
          if ($urandom % 3 == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
    join
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("rnd_drained", 28'(exp_q.size()), 28'd0);

    // Reset with beats in flight: nothing may surface afterwards.
    send(5'h06, 24'h112233, 24'h332211, 8'h00);
    send(5'h05, 24'h112233, 24'h332211, 8'h00);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 28'(out_valid), 28'd0);
    check("midrst_pix", 28'(out_pix), 28'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("midrst_after", 28'(out_valid), 28'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
